// File: rtl/psum_accumulator.sv
// Accumulates a programmable number of signed partial sums from the adder tree.
// The total is requantized (rounding shift, optional ReLU, saturation) to one activation.
module psum_accumulator #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [4:0]       shift,
  input  logic             relu_en,
  input  logic [IN_W-1:0]  psum_in,
  input  logic             psum_valid,
  output logic             psum_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [4:0]               r_shift;
  logic                     r_relu;
  logic signed [ACC_W-1:0]  r_acc;
  logic [OUT_W-1:0]         r_out_data;
  logic [ACC_W-1:0]         r_acc_out;
  logic                     r_out_valid;
  logic                     r_busy;

  logic                     w_psum_ready;
  logic                     w_load;
  logic                     w_beat;
  logic                     w_last;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [EXT_W-1:0]  w_ext;
  logic signed [EXT_W-1:0]  w_bias;
  logic signed [EXT_W-1:0]  w_rnd;
  logic signed [EXT_W-1:0]  w_shr;
  logic signed [EXT_W-1:0]  w_relu;
  logic [OUT_W-1:0]         w_sat;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && (len != '0)) w_state_nxt = S_ACCUM;
      S_ACCUM: if (psum_valid && (r_cnt == CNT_W'(1))) w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded strobes; psum_ready is the only combinational output
  always_comb begin
    w_psum_ready = 1'b0;
    w_load       = 1'b0;
    w_beat       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE:  w_load = start && (len != '0);
      S_ACCUM: begin
        w_psum_ready = 1'b1;
        w_beat       = psum_valid;
        w_last       = psum_valid && (r_cnt == CNT_W'(1));
      end
      default: ;
    endcase
  end

  // Requantization of the sum including the current beat
  always_comb begin
    w_sum  = r_acc + ACC_W'($signed(psum_in));
    w_ext  = EXT_W'(w_sum);
    w_bias = (r_shift != 5'd0) ? (EXT_W'(1) << (r_shift - 5'd1)) : '0;
    w_rnd  = w_ext + w_bias;
    w_shr  = w_rnd >>> r_shift;
    w_relu = (r_relu && w_shr[EXT_W-1]) ? '0 : w_shr;
    if (w_relu > SAT_MAX)      w_sat = OUT_W'(SAT_MAX);
    else if (w_relu < SAT_MIN) w_sat = OUT_W'(SAT_MIN);
    else                       w_sat = w_relu[OUT_W-1:0];
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_acc_out   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != S_IDLE);
      r_out_valid <= (w_state_nxt == S_OUT);
      if (w_load) begin
        r_cnt   <= len;
        r_shift <= shift;
        r_relu  <= relu_en;
        r_acc   <= '0;
      end else if (w_beat) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_out_data <= w_sat;
          r_acc_out  <= w_sum;
        end
      end
    end
  end

  assign psum_ready = w_psum_ready;
  assign out_data   = r_out_data;
  assign acc_out    = r_acc_out;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;

endmodule
